// File: rtl/xeng_pkg.sv
// Shared X-engine sizing helpers: log2 and the tap/antenna-index widths
// derived from the antenna count. xeng_top and the baseline-order generator
// both size their dump sequence from here, so the two always agree.
package xeng_pkg;

  localparam int N_ANTS_DEFAULT = 32;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // taps per antenna in one dump, including the autocorrelation tap
  function automatic int n_taps(input int n_ants);
    return n_ants / 2 + 1;
  endfunction

  // width of an antenna index
  function automatic int ant_bits(input int n_ants);
    return clog2(n_ants);
  endfunction

endpackage

// File: rtl/xeng_bl_order_gen_if.sv
// Sequencing strobes in (sync/en from xeng_top) and baseline labels out.
// The master side drives sync/en; the slave (the generator) drives labels.
interface xeng_bl_order_gen_if #(
  parameter int ANT_BITS = 5
);
  logic                sync;
  logic                en;
  logic [ANT_BITS-1:0] ant_a;
  logic [ANT_BITS-1:0] ant_b;
  logic                buf_sel;

  modport master (output sync, output en, input ant_a, input ant_b, input buf_sel);
  modport slave  (input sync, input en, output ant_a, output ant_b, output buf_sel);
endinterface

// File: rtl/xeng_wrap_counter.sv
// Modulo-M counter: clr forces zero and wins over inc; inc advances and
// wraps M-1 -> 0. tc flags the terminal value M-1 combinationally so a
// cascaded counter can use inc & tc as its own increment.
module xeng_wrap_counter
  import xeng_pkg::*;
#(
  parameter int M = 17,
  parameter int W = (clog2(M) < 1) ? 1 : clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(M - 1);

  assign tc = (count == LAST);

  // count register: clear beats increment, increment wraps at M-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : W'(count + 1'b1);
    end
  end

endmodule

// File: rtl/xeng_bl_order_gen.sv
// Baseline-order generator: labels each valid X-engine output word with
// (ant_a, ant_b, buf_sel). Zero latency: labels decode the current state in
// the same cycle en is high. Taps are the inner loop, antennas the outer.
module xeng_bl_order_gen
  import xeng_pkg::*;
#(
  parameter int N_ANTS = N_ANTS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  xeng_bl_order_gen_if.slave   bus
);

  localparam int ANT_BITS = ant_bits(N_ANTS);
  localparam int N_TAPS   = n_taps(N_ANTS);
  // N_TAPS-1 = N_ANTS/2 always fits in an antenna index, so the tap counter
  // shares the antenna width and ant_b can be a plain wrapping add.
  localparam int TAP_BITS = clog2(N_TAPS);

  logic [TAP_BITS-1:0] tap;
  logic                tap_tc;
  logic [ANT_BITS-1:0] ant;
  logic                ant_tc;
  logic                ant_inc;

  // antenna index moves on only when the last tap of this antenna is consumed
  assign ant_inc = bus.en & tap_tc;

  xeng_wrap_counter #(
    .M (N_TAPS),
    .W (TAP_BITS)
  ) u_tap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.sync),
    .inc   (bus.en),
    .count (tap),
    .tc    (tap_tc)
  );

  xeng_wrap_counter #(
    .M (N_ANTS),
    .W (ANT_BITS)
  ) u_ant_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.sync),
    .inc   (ant_inc),
    .count (ant),
    .tc    (ant_tc)
  );

  // The full-dump terminal count is not needed: both counters wrap on their
  // own, so the sequence restarts at (0,0) without a fresh sync.
  logic unused_ant_tc;
  assign unused_ant_tc = ant_tc;

  // Label decode. The last tap reaches half-way round the array, so antennas
  // in the upper half see the same baseline a second time: that copy is
  // flagged as the redundant buffer.
  assign bus.ant_a   = ant;
  assign bus.ant_b   = ant + ANT_BITS'(tap);
  assign bus.buf_sel = tap_tc & ant[ANT_BITS-1];

endmodule

// File: tb/tb_xeng_bl_order_gen.sv
// Directed and randomised checks of the baseline-order generator at
// N_ANTS=32 and N_ANTS=4. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_xeng_bl_order_gen;
  import xeng_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xeng_bl_order_gen_if #(.ANT_BITS(5)) bus32 ();
  xeng_bl_order_gen_if #(.ANT_BITS(2)) bus4 ();

  xeng_bl_order_gen #(.N_ANTS(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  xeng_bl_order_gen #(.N_ANTS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int word;
    int a;
    int b;
    int bs;
  } vec_t;

  vec_t tbl[24];
  int   cap_a[545];
  int   cap_b[545];
  int   cap_bs[545];

  task automatic chk_lbl(input string name, input int aa, input int ab, input int abs,
                         input int ea, input int eb, input int ebs);
    n_tests++;
    if (aa != ea || ab != eb || abs != ebs) begin
      n_fail++;
      $display("FAIL %s: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
               name, aa, ab, abs, ea, eb, ebs);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int ea, input int eb, input int ebs);
    chk_lbl(name, int'(bus32.ant_a), int'(bus32.ant_b), int'(bus32.buf_sel), ea, eb, ebs);
  endtask

  task automatic chk4(input string name, input int ea, input int eb, input int ebs);
    chk_lbl(name, int'(bus4.ant_a), int'(bus4.ant_b), int'(bus4.buf_sel), ea, eb, ebs);
  endtask

  // reference decode of (antenna, tap) for an n-antenna array
  task automatic model_lbl(input int n, input int i, input int t,
                           output int a, output int b, output int bs);
    a  = i;
    b  = (i + t) % n;
    bs = (t == n / 2 && i >= n / 2) ? 1 : 0;
  endtask

  // reference state update for one clock edge
  task automatic model_step(input int n, input bit r, input bit s, input bit e,
                            inout int i, inout int t);
    if (r || s) begin
      i = 0;
      t = 0;
    end else if (e) begin
      if (t < n / 2) begin
        t = t + 1;
      end else begin
        t = 0;
        i = (i == n - 1) ? 0 : i + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ea, eb, ebs, nbuf, n;
    int i32, t32, i4, t4;
    bit r, s32, e32, s4, e4;

    // hand-computed labels for one dump at N_ANTS=32 (17 taps per antenna)
    for (int k = 0; k < 17; k++) tbl[k] = '{k, 0, k, 0};
    tbl[17] = '{17,  1,  1, 0};
    tbl[18] = '{33,  1, 17, 0};
    tbl[19] = '{271, 15, 31, 0};
    tbl[20] = '{288, 16,  0, 1};
    tbl[21] = '{527, 31, 31, 0};
    tbl[22] = '{528, 31,  0, 0};
    tbl[23] = '{543, 31, 15, 1};

    rst = 1'b1;
    bus32.sync = 1'b0; bus32.en = 1'b0;
    bus4.sync  = 1'b0; bus4.en  = 1'b0;
    #2;
    chk32("reset32", 0, 0, 0);
    chk4("reset4", 0, 0, 0);
    tick();
    rst = 1'b0;

    // one full dump plus one word with en held high
    bus32.sync = 1'b1;
    tick();
    bus32.sync = 1'b0;
    bus32.en   = 1'b1;
    for (int w = 0; w < 545; w++) begin
      @(negedge clk);
      cap_a[w]  = int'(bus32.ant_a);
      cap_b[w]  = int'(bus32.ant_b);
      cap_bs[w] = int'(bus32.buf_sel);
      tick();
    end
    bus32.en = 1'b0;

    foreach (tbl[k]) begin
      chk_lbl($sformatf("dump_word%0d", tbl[k].word),
              cap_a[tbl[k].word], cap_b[tbl[k].word], cap_bs[tbl[k].word],
              tbl[k].a, tbl[k].b, tbl[k].bs);
    end
    chk_lbl("wrap_word544", cap_a[544], cap_b[544], cap_bs[544], 0, 0, 0);
    nbuf = 0;
    for (int w = 0; w < 544; w++) nbuf += cap_bs[w];
    chk_int("buf_sel_count", nbuf, 16);

    // en with random gaps: labels advance only on en words, hold otherwise
    bus32.sync = 1'b1;
    tick();
    bus32.sync = 1'b0;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      bus32.en = 1'(($urandom_range(0, 99) < 60) ? 1 : 0);
      @(negedge clk);
      model_lbl(32, n / 17, n % 17, ea, eb, ebs);
      chk32($sformatf("gap_cyc%0d", c), ea, eb, ebs);
      if (bus32.en) n++;
      tick();
    end

    // sync coinciding with word 100 (i=5, t=15)
    bus32.sync = 1'b1;
    bus32.en   = 1'b0;
    tick();
    bus32.sync = 1'b0;
    bus32.en   = 1'b1;
    repeat (100) tick();
    bus32.sync = 1'b1;
    @(negedge clk);
    chk32("sync_word100", 5, 20, 0);
    tick();
    bus32.sync = 1'b0;
    @(negedge clk);
    chk32("after_sync", 0, 0, 0);
    repeat (30) tick();
    @(negedge clk);
    chk32("pre_rst_word30", 1, 14, 0);
    #2;
    rst = 1'b1;
    #1;
    chk32("async_rst", 0, 0, 0);
    // sync/en ignored while rst high
    bus32.en = 1'b1;
    tick();
    @(negedge clk);
    chk32("rst_held", 0, 0, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk32("rst_release", 0, 0, 0);
    tick();
    @(negedge clk);
    chk32("post_rst_word1", 0, 1, 0);
    bus32.en = 1'b0;
    tick();

    // randomised scoreboard on both array sizes
    bus32.sync = 1'b1;
    bus4.sync  = 1'b1;
    tick();
    i32 = 0; t32 = 0; i4 = 0; t4 = 0;
    for (int c = 0; c < 6000; c++) begin
      r   = ($urandom_range(0, 2999) == 0);
      s32 = ($urandom_range(0, 1999) == 0);
      s4  = ($urandom_range(0, 199) == 0);
      e32 = ($urandom_range(0, 99) < 80);
      e4  = ($urandom_range(0, 99) < 70);
      rst = r;
      bus32.sync = s32; bus32.en = e32;
      bus4.sync  = s4;  bus4.en  = e4;
      if (r) begin
        i32 = 0; t32 = 0; i4 = 0; t4 = 0;
      end
      @(negedge clk);
      model_lbl(32, i32, t32, ea, eb, ebs);
      chk32($sformatf("rand32_cyc%0d", c), ea, eb, ebs);
      model_lbl(4, i4, t4, ea, eb, ebs);
      chk4($sformatf("rand4_cyc%0d", c), ea, eb, ebs);
      @(posedge clk);
      model_step(32, r, s32, e32, i32, t32);
      model_step(4, r, s4, e4, i4, t4);
      #1;
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
